mul_seq_core: RTL

Sequential signed shift-add multiplier core that consumes the single-cycle press tick from the push-button detector as its start command. It samples two signed operands (from the board switches), computes their product over WIDTH iterations using magnitudes plus a final sign fix-up, and presents a held result with a one-cycle done pulse for the display logic downstream.

---
 rtl/mul_seq_core.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mul_seq_core.sv
// -----------------------------------------------------------------------------
// mul_seq_core
//
// Sequential signed shift-add multiplier. A start tick in IDLE captures both
// operands as magnitudes plus a result sign. RUN performs one add/shift step
// per cycle. FINAL applies the sign and publishes the product with a
// one-cycle done pulse. The product is held until the next completion.
//
// Optional feature (compile-time macro):
//   MUL_EARLY_EXIT_EN - defined: RUN ends as soon as the remaining multiplier
//                       bits are all zero, so latency tracks the highest set
//                       bit of |B|. Undefined: always WIDTH iterations, with a
//                       fixed latency of WIDTH+2 cycles.
//
// Parameters:
//   WIDTH         operand width in bits; the product is 2*WIDTH bits wide
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   start         one-cycle start tick, sampled only in IDLE
//   multiplicand  signed operand A, sampled with start
//   multiplier    signed operand B, sampled with start
//   product       signed A*B, updated only on completion
//   busy          high while an operation is in progress
//   done          one-cycle pulse in the first cycle of a new product
// -----------------------------------------------------------------------------
module mul_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  // The counter must be able to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t               state_reg;
  logic [2*WIDTH-1:0]   mc_reg;       // shifted multiplicand magnitude
  logic [WIDTH-1:0]     mr_reg;       // remaining multiplier magnitude bits
  logic [2*WIDTH-1:0]   acc_reg;      // unsigned partial product
  logic [CW-1:0]        cnt_reg;      // completed iterations
  logic                 sign_reg;     // result is negative
  logic [2*WIDTH-1:0]   product_reg;
  logic                 busy_reg;
  logic                 done_reg;

  // Magnitudes are taken as WIDTH-bit unsigned values, so the most negative
  // operand maps to 2^(WIDTH-1) without overflow.
  logic [WIDTH-1:0]     a_mag_next;
  logic [WIDTH-1:0]     b_mag_next;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   signed_next;

  always_comb begin
    a_mag_next = multiplicand[WIDTH-1] ? (~multiplicand + 1'b1) : multiplicand;
    b_mag_next = multiplier[WIDTH-1]   ? (~multiplier + 1'b1)   : multiplier;
  end

  always_comb begin
    acc_next = mr_reg[0] ? (acc_reg + mc_reg) : acc_reg;
  end

  // Two's-complement negation of zero is zero, so a zero magnitude with the
  // sign set still yields a zero product.
  always_comb begin
    signed_next = sign_reg ? (~acc_reg + 1'b1) : acc_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      mc_reg      <= '0;
      mr_reg      <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      sign_reg    <= 1'b0;
      product_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mc_reg    <= {{WIDTH{1'b0}}, a_mag_next};
            mr_reg    <= b_mag_next;
            sign_reg  <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end

        RUN: begin
`ifdef MUL_EARLY_EXIT_EN
          // No multiplier bits left: the accumulator is already final, so
          // this cycle takes the FINAL role directly. That keeps the done
          // pulse at cycle iterations+2 (cycle 2 for a zero multiplier).
          if (mr_reg == '0) begin
            product_reg <= signed_next;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            acc_reg <= acc_next;
            mc_reg  <= mc_reg << 1;
            mr_reg  <= mr_reg >> 1;
            cnt_reg <= cnt_reg + CW'(1);
            if (cnt_reg == LAST_ITER) begin
              state_reg <= FINAL;
            end
          end
`else
          acc_reg <= acc_next;
          mc_reg  <= mc_reg << 1;
          mr_reg  <= mr_reg >> 1;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_ITER) begin
            state_reg <= FINAL;
          end
`endif
        end

        FINAL: begin
          product_reg <= signed_next;
          done_reg    <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule
